sw_event_encoder: RTL and testbench

Converts the 18 board slide switches into a serialized stream of switch-toggle events, each carrying the switch index and its new level, over a valid/ready handshake. It is the encoder counterpart of the LED path, which decodes a 5-bit `led_index` into a one-hot LED. Downstream hit/score logic consumes one event per handshake instead of scanning raw `SW`. Simultaneous toggles are queued and drained lowest index first; an overlapping re-toggle is counted and merged, never lost silently.

---
 rtl/sw_event_encoder.sv | 135 +++++++++++++
 tb/tb_sw_event_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sw_event_encoder.sv
// sw_event_encoder
// Turns the board slide switches into a stream of toggle events. Each event
// carries the switch index and the level it moved to. Events leave over a
// valid/ready handshake. Toggles that arrive together are queued in a pending
// bitmap and drained lowest index first. A toggle that hits a switch whose
// event is still queued is merged into that event and counted in drop_count.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sw           raw asynchronous switch levels, NUM_SW bits
//   enable       when low, new toggles are ignored; queued events still drain
//   event_valid  event_index / event_level hold an event
//   event_ready  consumer accepts the event when valid and ready are both high
//   event_index  switch number of the presented event
//   event_level  switch level after the toggle
//   pending      switches with a queued event not yet presented
//   drop_count   saturating count of cycles with merged toggles
module sw_event_encoder #(
  parameter int NUM_SW = 18,
  parameter int IDX_W  = 5,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic              enable,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [IDX_W-1:0]  event_index,
  output logic              event_level,
  output logic [NUM_SW-1:0] pending,
  output logic [DROP_W-1:0] drop_count
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_SW-1:0] s1_q, s2_q, prev_q;
  logic [NUM_SW-1:0] pending_q, pending_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [NUM_SW-1:0] tog;
  logic [NUM_SW-1:0] sel_oh;
  logic [NUM_SW-1:0] clr;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_lvl;
  logic              sel_found;
  logic              slot_free;
  logic              load;
  logic              merge;

  // Stage p0/p1: two-flop synchronizer plus history register. On reset they
  // all take the present switch levels so switches already up make no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= sw;
      s2_q   <= sw;
      prev_q <= sw;
    end else begin
      s1_q   <= sw;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_comb begin
    tog = (s2_q ^ prev_q) & {NUM_SW{enable}};

    // Descending scan so the last hit, the lowest set index, wins.
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_lvl   = 1'b0;
    sel_oh    = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_lvl   = s2_q[i];
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end

    slot_free = !valid_q || event_ready;
    load      = slot_free && sel_found;
    clr       = load ? sel_oh : '0;

    // A fresh toggle on the bit being loaded re-arms it (set beats clear).
    pending_d = tog | (pending_q & ~clr);

    // Any number of merges in one cycle counts once.
    merge  = |(tog & pending_q & ~clr);
    drop_d = merge ? sat_inc(drop_q) : drop_q;

    valid_d = valid_q;
    index_d = index_q;
    level_d = level_q;
    if (load) begin
      valid_d = 1'b1;
      index_d = sel_idx;
      level_d = sel_lvl;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // Stage p2: pending bitmap, drop counter and the single output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      level_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
    end
  end

  assign event_valid = valid_q;
  assign event_index = index_q;
  assign event_level = level_q;
  assign pending     = pending_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_sw_event_encoder.sv
module tb_sw_event_encoder;

  localparam int NUM_SW = 18;
  localparam int IDX_W  = 5;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_SW-1:0] sw;
  logic              enable;
  logic              event_valid;
  logic              event_ready;
  logic [IDX_W-1:0]  event_index;
  logic              event_level;
  logic [NUM_SW-1:0] pending;
  logic [DROP_W-1:0] drop_count;

  int vectors = 0;
  int fails   = 0;

  sw_event_encoder #(.NUM_SW(NUM_SW), .IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .enable     (enable),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_index(event_index),
    .event_level(event_level),
    .pending    (pending),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw = '0; enable = 1'b1; event_ready = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset_valid",   32'(event_valid), 32'h0);
    check("reset_index",   32'(event_index), 32'h0);
    check("reset_level",   32'(event_level), 32'h0);
    check("reset_pending", 32'(pending),     32'h0);
    check("reset_drop",    32'(drop_count),  32'h0);

    // Single toggle on sw[7]: valid for exactly cycle 3.
    sw[7] = 1'b1;
    step(2);
    check("single_c1_valid", 32'(event_valid), 32'h0);
    step(1);
    check("single_c2_pending", 32'(pending), 32'h80);
    check("single_c2_valid",   32'(event_valid), 32'h0);
    step(1);
    check("single_c3_valid",   32'(event_valid), 32'h1);
    check("single_c3_index",   32'(event_index), 32'd7);
    check("single_c3_level",   32'(event_level), 32'h1);
    check("single_c3_pending", 32'(pending),     32'h0);
    step(1);
    check("single_c4_valid",   32'(event_valid), 32'h0);
    check("single_drop",       32'(drop_count),  32'h0);

    // Simultaneous toggles on 0, 3, 17: drained lowest first.
    sw[0] = 1'b1; sw[3] = 1'b1; sw[17] = 1'b1;
    step(3);
    check("simul_pending", 32'(pending), 32'h20009);
    step(1);
    check("simul_a_valid", 32'(event_valid), 32'h1);
    check("simul_a_index", 32'(event_index), 32'd0);
    check("simul_a_level", 32'(event_level), 32'h1);
    step(1);
    check("simul_b_valid", 32'(event_valid), 32'h1);
    check("simul_b_index", 32'(event_index), 32'd3);
    check("simul_b_level", 32'(event_level), 32'h1);
    step(1);
    check("simul_c_valid", 32'(event_valid), 32'h1);
    check("simul_c_index", 32'(event_index), 32'd17);
    check("simul_c_level", 32'(event_level), 32'h1);
    step(1);
    check("simul_end_valid", 32'(event_valid), 32'h0);

    // Backpressure: 5 held while 2 queues behind it.
    event_ready = 1'b0;
    sw[5] = 1'b1;
    step(4);
    check("bp_first_valid", 32'(event_valid), 32'h1);
    check("bp_first_index", 32'(event_index), 32'd5);
    step(6);
    sw[2] = 1'b1;
    step(3);
    check("bp_hold_valid",   32'(event_valid), 32'h1);
    check("bp_hold_index",   32'(event_index), 32'd5);
    check("bp_hold_pending", 32'(pending),     32'h4);
    check("bp_drop",         32'(drop_count),  32'h0);
    event_ready = 1'b1;
    step(1);
    check("bp_next_valid", 32'(event_valid), 32'h1);
    check("bp_next_index", 32'(event_index), 32'd2);
    check("bp_next_level", 32'(event_level), 32'h1);
    step(1);
    check("bp_end_valid", 32'(event_valid), 32'h0);

    // Merge and saturation on sw[9] with the consumer stalled.
    event_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      sw[9] = ~sw[9];
      step(2);
    end
    step(4);
    check("merge12_valid",   32'(event_valid), 32'h1);
    check("merge12_index",   32'(event_index), 32'd9);
    check("merge12_level",   32'(event_level), 32'h1);
    check("merge12_pending", 32'(pending),     32'h200);
    check("merge12_drop",    32'(drop_count),  32'd10);
    for (int t = 0; t < 288; t++) begin
      sw[9] = ~sw[9];
      step(2);
    end
    step(4);
    check("merge300_index",   32'(event_index), 32'd9);
    check("merge300_pending", 32'(pending),     32'h200);
    check("merge300_drop",    32'(drop_count),  32'hFF);
    event_ready = 1'b1;
    step(1);
    check("merge_rel_valid", 32'(event_valid), 32'h1);
    check("merge_rel_index", 32'(event_index), 32'd9);
    check("merge_rel_level", 32'(event_level), 32'h0);
    step(1);
    check("merge_rel_end",   32'(event_valid), 32'h0);
    check("merge_rel_drop",  32'(drop_count),  32'hFF);

    // Reset with every switch up: no events afterwards.
    sw = '1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rstup_drop", 32'(drop_count), 32'h0);
    for (int t = 0; t < 20; t++) begin
      step(1);
      check("rstup_valid", 32'(event_valid), 32'h0);
    end

    // Reset while three events are queued.
    event_ready = 1'b0;
    sw[1] = 1'b0; sw[6] = 1'b0; sw[11] = 1'b0;
    step(3);
    check("rstq_pending_before", 32'(pending), 32'h842);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rstq_pending", 32'(pending),     32'h0);
    check("rstq_valid",   32'(event_valid), 32'h0);

    // Enable gating.
    event_ready = 1'b1;
    enable = 1'b0;
    sw[4] = 1'b0;
    step(6);
    enable = 1'b1;
    step(4);
    check("en_off_valid",   32'(event_valid), 32'h0);
    check("en_off_pending", 32'(pending),     32'h0);
    check("en_off_drop",    32'(drop_count),  32'h0);
    sw[4] = 1'b1;
    step(3);
    check("en_pend_pending", 32'(pending), 32'h10);
    enable = 1'b0;
    step(1);
    check("en_drain_valid", 32'(event_valid), 32'h1);
    check("en_drain_index", 32'(event_index), 32'd4);
    check("en_drain_level", 32'(event_level), 32'h1);
    step(1);
    check("en_drain_end",   32'(event_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
